modexp_ctrl: RTL and testbench
==============================

Name: modexp_ctrl

Overview:
- Sequencer for one external `montgomery` multiplier instance. It computes the RSA modular exponentiation X^E mod M by left-to-right square-and-multiply in the Montgomery domain, then does a final conversion out of that domain.
- It sits between the top-level RSA register interface and the multiplier. It only issues operands and collects results; it holds no arithmetic of its own.

Parameters:
- WIDTH, 1024: operand and modulus width; the Montgomery radix is R = 2^WIDTH.
- EXP_W, 1024: exponent register width.
- LEN_W, 11: width of the exponent-length input; must be at least clog2(EXP_W)+1.
- DONE_GUARD, 2: number of cycles after mm_start during which mm_done is ignored.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request; honoured only in IDLE.
- in_x_mont  in  WIDTH  base already in the Montgomery domain (X·R mod M).
- in_one_mont  in  WIDTH  R mod M, i.e. Montgomery "1".
- in_m  in  WIDTH  modulus; must be odd.
- in_e  in  EXP_W  exponent.
- in_e_len  in  LEN_W  number of significant exponent bits; values above EXP_W are clamped to EXP_W.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when result is valid.
- result  out  WIDTH  X^E mod M; holds its value until the next accepted start.
- mm_start  out  1  one-cycle start to the multiplier.
- mm_a, mm_b, mm_m  out  WIDTH  multiplier operands; stable from mm_start until mm_done is sampled.
- mm_result  in  WIDTH  multiplier output, A·B·R^-1 mod M.
- mm_done  in  1  multiplier completion level. It may stay high from the previous operation.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy, done and mm_start = 0; result, mm_a, mm_b, mm_m, accumulator and index all cleared to 0.
- Reset asserted mid-operation aborts the operation. No done pulse is produced.
- On accepted start: latch in_x_mont, in_e and in_m. Set acc = in_one_mont and idx = min(in_e_len, EXP_W).
- Exponent bits at positions idx and above are ignored.
- States and transitions:
  - IDLE: start -> (idx==0 ? CONV_ISSUE : SQR_ISSUE).
  - SQR_ISSUE: drive mm_a = mm_b = acc; pulse mm_start; decrement idx; -> SQR_WAIT.
  - SQR_WAIT: on a valid done, acc = mm_result; then e[idx]=1 -> MUL_ISSUE, otherwise (idx==0 ? CONV_ISSUE : SQR_ISSUE).
  - MUL_ISSUE: drive mm_a = acc, mm_b = x; pulse mm_start; -> MUL_WAIT.
  - MUL_WAIT: on a valid done, acc = mm_result; -> (idx==0 ? CONV_ISSUE : SQR_ISSUE).
  - CONV_ISSUE: drive mm_a = acc, mm_b = 1; pulse mm_start; -> CONV_WAIT.
  - CONV_WAIT: on a valid done, result = mm_result; -> DONE.
  - DONE: done = 1 for one cycle, busy drops in the same cycle; -> IDLE.
- A valid done means mm_done sampled high at least DONE_GUARD cycles after the mm_start cycle. This rejects the stale high level left by the previous operation.
- mm_m = latched modulus for the whole operation.
- Number of mm_start pulses per operation = len + popcount(e[len-1:0]) + 1.
- Latency = sum of the multiplier latencies + 2 cycles per multiplication + 2 cycles of overhead.
- start while busy is ignored; latched operands and progress are unaffected.
- start in the DONE cycle is ignored; start in the following IDLE cycle is accepted.
- len=0 -> only the conversion runs; result = 1 mod M.
- No arithmetic range check is done: results are correct only for inputs below M and M odd.

Decomposition:
- Shared package modexp_pkg: state encoding constants (IDLE, SQR_ISSUE, SQR_WAIT, MUL_ISSUE, MUL_WAIT, CONV_ISSUE, CONV_WAIT, DONE) and WIDTH/EXP_W defaults.
- One natural sub-module, mm_issue: the mm_start pulse, the guard counter and valid-done detection, reused by every *_WAIT state.
- Exponent bit selection stays inline as e[idx].

Test Plan:
- WIDTH=8 with a behavioural Montgomery model (R=256). Inputs M=13, one=9, x_mont=5 (X=2), e=5, len=3 -> result=6 (2^5 mod 13); exactly 6 mm_start pulses; done one cycle wide.
- Same inputs but e=0b1101, len=3 -> high bit ignored, result=6. Then len=0 -> result=1 with exactly 1 mm_start.
- e=0, len=3 -> result=1; 4 mm_start pulses (3 squares plus conversion).
- Model holds mm_done high between operations; back-to-back runs of 3^7 mod 13 (x_mont = 27 mod 13 = 1) -> result=3 both times. No premature acc update inside the guard window.
- start pulsed mid-operation -> ignored; result still 6.
- resetn low during MUL_WAIT -> busy=0 asynchronously, no done. A fresh start after release completes correctly.

Source files
------------

// File: rtl/modexp_pkg.sv
// Shared definitions for the modular-exponentiation sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package modexp_pkg;

  localparam int DEF_WIDTH = 1024;
  localparam int DEF_EXP_W = 1024;

  // Sequencer states: each multiplication is an ISSUE cycle followed by a WAIT phase.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SQR_ISSUE  = 3'd1,
    SQR_WAIT   = 3'd2,
    MUL_ISSUE  = 3'd3,
    MUL_WAIT   = 3'd4,
    CONV_ISSUE = 3'd5,
    CONV_WAIT  = 3'd6,
    DONE       = 3'd7
  } state_t;

endpackage

// File: rtl/mm_issue.sv
// Multiplier handshake helper: registers the mm_start pulse and qualifies mm_done.
// Latency: mm_start one cycle after issue; done_vld no earlier than DONE_GUARD cycles after mm_start.
// Backpressure: none; the caller holds its WAIT state until done_vld.
// Ports: issue (request a pulse), mm_done (raw multiplier level), mm_start (pulse out),
//        done_vld (mm_done accepted as belonging to the current operation).
module mm_issue #(
  parameter int DONE_GUARD = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic issue,
  input  logic mm_done,
  output logic mm_start,
  output logic done_vld
);

  localparam int CW = (DONE_GUARD > 0) ? $clog2(DONE_GUARD + 1) : 1;
  localparam logic [CW-1:0] GUARD = CW'(DONE_GUARD);

  logic [CW-1:0] guard_cnt;

  // The counter is loaded together with mm_start, so it reads DONE_GUARD in the
  // mm_start cycle and reaches zero exactly DONE_GUARD cycles later. Until then a
  // high mm_done is the level left over from the previous multiplication.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mm_start  <= 1'b0;
      guard_cnt <= '0;
    end else begin
      mm_start <= issue;
      if (issue)
        guard_cnt <= GUARD;
      else if (guard_cnt != '0)
        guard_cnt <= guard_cnt - 1'b1;
    end
  end

  assign done_vld = mm_done && (guard_cnt == '0);

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer for one Montgomery multiplier, ending with a conversion out of the Montgomery domain.
// Latency: sum of multiplier latencies + 2 cycles per multiplication + 2 cycles (start cycle to done cycle inclusive).
// Backpressure: start is honoured only in IDLE; start while busy or in the done cycle is dropped.
// Ports: start/in_* (request and operands), busy/done/result (status and X^E mod M),
//        mm_start/mm_a/mm_b/mm_m (multiplier request), mm_result/mm_done (multiplier response).
import modexp_pkg::*;

module modexp_ctrl #(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int EXP_W      = DEF_EXP_W,
  parameter int LEN_W      = 11,
  parameter int DONE_GUARD = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_x_mont,
  input  logic [WIDTH-1:0] in_one_mont,
  input  logic [WIDTH-1:0] in_m,
  input  logic [EXP_W-1:0] in_e,
  input  logic [LEN_W-1:0] in_e_len,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  output logic [WIDTH-1:0] mm_m,
  input  logic [WIDTH-1:0] mm_result,
  input  logic             mm_done
);

  localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [LEN_W-1:0] EXP_W_L = LEN_W'(EXP_W);

  state_t           state;
  logic [WIDTH-1:0] x_q;
  logic [EXP_W-1:0] e_q;
  logic [WIDTH-1:0] acc;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] len_c;
  logic             issue;
  logic             done_vld;
  logic             e_bit;
  logic             idx_zero;

  assign len_c    = (in_e_len > EXP_W_L) ? EXP_W_L : in_e_len;
  // idx is decremented in the ISSUE cycle of a square, so in SQR_WAIT it already
  // points at the exponent bit that decides whether a multiply follows.
  assign e_bit    = e_q[idx[IW-1:0]];
  assign idx_zero = (idx == '0);
  assign issue    = (state == SQR_ISSUE) || (state == MUL_ISSUE) || (state == CONV_ISSUE);

  mm_issue #(
    .DONE_GUARD (DONE_GUARD)
  ) u_mm_issue (
    .clk      (clk),
    .resetn   (resetn),
    .issue    (issue),
    .mm_done  (mm_done),
    .mm_start (mm_start),
    .done_vld (done_vld)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      mm_a   <= '0;
      mm_b   <= '0;
      mm_m   <= '0;
      x_q    <= '0;
      e_q    <= '0;
      acc    <= '0;
      idx    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_q   <= in_x_mont;
            e_q   <= in_e;
            mm_m  <= in_m;
            acc   <= in_one_mont;
            idx   <= len_c;
            busy  <= 1'b1;
            state <= (len_c == '0) ? CONV_ISSUE : SQR_ISSUE;
          end
        end
        SQR_ISSUE: begin
          mm_a  <= acc;
          mm_b  <= acc;
          idx   <= idx - 1'b1;
          state <= SQR_WAIT;
        end
        SQR_WAIT: begin
          if (done_vld) begin
            acc <= mm_result;
            if (e_bit)
              state <= MUL_ISSUE;
            else
              state <= idx_zero ? CONV_ISSUE : SQR_ISSUE;
          end
        end
        MUL_ISSUE: begin
          mm_a  <= acc;
          mm_b  <= x_q;
          state <= MUL_WAIT;
        end
        MUL_WAIT: begin
          if (done_vld) begin
            acc   <= mm_result;
            state <= idx_zero ? CONV_ISSUE : SQR_ISSUE;
          end
        end
        CONV_ISSUE: begin
          // Multiplying by plain 1 strips the R factor: acc*1*R^-1 mod M.
          mm_a  <= acc;
          mm_b  <= WIDTH'(1);
          state <= CONV_WAIT;
        end
        CONV_WAIT: begin
          if (done_vld) begin
            result <= mm_result;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
module tb_modexp_ctrl;

  logic       clk;
  logic       resetn;
  logic       start;
  logic [7:0] in_x_mont;
  logic [7:0] in_one_mont;
  logic [7:0] in_m;
  logic [7:0] in_e;
  logic [3:0] in_e_len;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       mm_start;
  logic [7:0] mm_a;
  logic [7:0] mm_b;
  logic [7:0] mm_m;
  logic [7:0] mm_result;
  logic       mm_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // multiplier model bookkeeping
  int         pulses = 0;
  int         lat_sum = 0;
  logic [7:0] cur_m = 8'd0;

  modexp_ctrl #(
    .WIDTH      (8),
    .EXP_W      (8),
    .LEN_W      (4),
    .DONE_GUARD (2)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .in_x_mont   (in_x_mont),
    .in_one_mont (in_one_mont),
    .in_m        (in_m),
    .in_e        (in_e),
    .in_e_len    (in_e_len),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .mm_start    (mm_start),
    .mm_a        (mm_a),
    .mm_b        (mm_b),
    .mm_m        (mm_m),
    .mm_result   (mm_result),
    .mm_done     (mm_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // R^-1 mod m for R = 256, found by search.
  function automatic int rinv_of(input int m);
    for (int r = 1; r < m; r++)
      if (((256 * r) % m) == 1) return r;
    return 0;
  endfunction

  function automatic logic [7:0] mont(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
    int mm;
    mm = int'(m);
    if (mm == 0) return 8'd0;
    return 8'((((int'(a) * int'(b)) % mm) * rinv_of(mm)) % mm);
  endfunction

  function automatic int eff_len(input logic [3:0] len);
    return (int'(len) > 8) ? 8 : int'(len);
  endfunction

  function automatic int eff_exp(input logic [7:0] e, input logic [3:0] len);
    return int'(e) & ((1 << eff_len(len)) - 1);
  endfunction

  // X^E mod M by repeated multiplication of the plain-domain base.
  function automatic logic [7:0] pow_ref(input logic [7:0] x_mont, input logic [7:0] m,
                                         input logic [7:0] e, input logic [3:0] len);
    int mm, xx, r, ee;
    mm = int'(m);
    xx = (int'(x_mont) * rinv_of(mm)) % mm;
    ee = eff_exp(e, len);
    r  = 1 % mm;
    for (int i = 0; i < ee; i++) r = (r * xx) % mm;
    return 8'(r);
  endfunction

  // Multiplier model: latency 2..6 cycles; mm_done stays high with the previous
  // result through the first two cycles after mm_start, then drops until ready.
  initial begin : mm_model
    bit         pending;
    int         k;
    int         lat;
    logic [7:0] pend_res;
    logic [7:0] pa;
    logic [7:0] pb;
    pending   = 1'b0;
    k         = 0;
    lat       = 0;
    pend_res  = 8'd0;
    pa        = 8'd0;
    pb        = 8'd0;
    mm_done   = 1'b1;
    mm_result = 8'd0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          k++;
          if (k >= lat) begin
            chk(32'({mm_a, mm_b}), 32'({pa, pb}), "operands stable");
            mm_result = pend_res;
            mm_done   = 1'b1;
            pending   = 1'b0;
          end else if (k >= 2) begin
            mm_done = 1'b0;
          end
        end
        if (mm_start) begin
          chk(32'(mm_m), 32'(cur_m), "mm_m latched");
          pending  = 1'b1;
          k        = 0;
          lat      = $urandom_range(2, 6);
          lat_sum += lat;
          pulses++;
          pa       = mm_a;
          pb       = mm_b;
          pend_res = mont(mm_a, mm_b, mm_m);
        end
      end
    end
  end

  task automatic run_op(input logic [7:0] x, input logic [7:0] m, input logic [7:0] e,
                        input logic [3:0] len, input int poke, input string tag,
                        output logic [7:0] res);
    int s;
    int d;
    bit seen;
    int exp_pulses;
    logic [7:0] exp_res;
    exp_pulses = eff_len(len) + $countones(eff_exp(e, len)) + 1;
    exp_res    = pow_ref(x, m, e, len);
    @(negedge clk);
    in_x_mont   = x;
    in_m        = m;
    in_one_mont = 8'(256 % int'(m));
    in_e        = e;
    in_e_len    = len;
    cur_m       = m;
    pulses      = 0;
    lat_sum     = 0;
    start       = 1'b1;
    s           = cyc;
    @(negedge clk);
    start = 1'b0;
    chk(32'(busy), 32'd1, {tag, " busy after start"});
    seen = 1'b0;
    d    = 0;
    for (int i = 1; i <= 2000; i++) begin
      if (done) begin
        seen = 1'b1;
        d    = cyc;
        break;
      end
      start = (i == poke);
      if (i == poke) begin
        in_x_mont = 8'($urandom);
        in_m      = 8'($urandom) | 8'd1;
        in_e      = 8'($urandom);
        in_e_len  = 4'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk(32'(seen), 32'd1, {tag, " done seen before timeout"});
    res = result;
    if (seen) begin
      chk(32'(busy), 32'd0, {tag, " busy low with done"});
      chk(32'(result), 32'(exp_res), {tag, " result"});
      chk(32'(pulses), 32'(exp_pulses), {tag, " mm_start count"});
      chk(32'(d - s + 1), 32'(lat_sum + 2 * exp_pulses + 2), {tag, " latency"});
      @(negedge clk);
      chk(32'(done), 32'd0, {tag, " done one cycle"});
    end
  endtask

  initial begin : stim
    logic [7:0] r;
    logic [7:0] rm;
    logic [7:0] rx;
    bit         stray_done;
    int         w;
    resetn      = 1'b0;
    start       = 1'b0;
    in_x_mont   = 8'd0;
    in_one_mont = 8'd0;
    in_m        = 8'd0;
    in_e        = 8'd0;
    in_e_len    = 4'd0;
    repeat (3) @(negedge clk);
    chk(32'(busy), 32'd0, "reset busy");
    chk(32'(done), 32'd0, "reset done");
    chk(32'(mm_start), 32'd0, "reset mm_start");
    chk(32'(result), 32'd0, "reset result");
    chk(32'({mm_a, mm_b, mm_m}), 32'd0, "reset operands");
    resetn = 1'b1;

    // 2^5 mod 13
    run_op(8'd5, 8'd13, 8'd5, 4'd3, 0, "x2e5", r);
    chk(32'(r), 32'd6, "x2e5 const");
    // bit 3 set but outside len
    run_op(8'd5, 8'd13, 8'hD, 4'd3, 0, "e1101", r);
    chk(32'(r), 32'd6, "e1101 const");
    run_op(8'd5, 8'd13, 8'hD, 4'd0, 0, "len0", r);
    chk(32'(r), 32'd1, "len0 const");
    run_op(8'd5, 8'd13, 8'd0, 4'd3, 0, "e0", r);
    chk(32'(r), 32'd1, "e0 const");
    // back-to-back with mm_done stale-high: 3^7 mod 13
    run_op(8'd1, 8'd13, 8'd7, 4'd3, 0, "b2b1", r);
    chk(32'(r), 32'd3, "b2b1 const");
    run_op(8'd1, 8'd13, 8'd7, 4'd3, 0, "b2b2", r);
    chk(32'(r), 32'd3, "b2b2 const");
    // start pulse with garbage operands while busy
    run_op(8'd5, 8'd13, 8'd5, 4'd3, 5, "poke", r);
    chk(32'(r), 32'd6, "poke const");

    // reset during MUL_WAIT: second pulse of 2^5 (bit 2 set) is the multiply
    @(negedge clk);
    in_x_mont   = 8'd5;
    in_m        = 8'd13;
    in_one_mont = 8'd9;
    in_e        = 8'd5;
    in_e_len    = 4'd3;
    cur_m       = 8'd13;
    pulses      = 0;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    #1;
    while (pulses < 2 && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk(32'(pulses >= 2), 32'd1, "reach mul pulse");
    @(negedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk(32'(busy), 32'd0, "async reset busy");
    chk(32'(mm_start), 32'd0, "async reset mm_start");
    chk(32'(result), 32'd0, "async reset result");
    stray_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) resetn = 1'b1;
      if (done) stray_done = 1'b1;
    end
    chk(32'(stray_done), 32'd0, "no done after abort");
    run_op(8'd5, 8'd13, 8'd5, 4'd3, 0, "after reset", r);
    chk(32'(r), 32'd6, "after reset const");

    // randomized operands, odd moduli, lengths including clamped ones
    for (int n = 0; n < 12; n++) begin
      rm = 8'($urandom_range(1, 127) * 2 + 1);
      rx = 8'($urandom_range(0, int'(rm) - 1));
      run_op(rx, rm, 8'($urandom), 4'($urandom_range(0, 15)), (n % 3 == 0) ? 4 : 0, "rand", r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
